// File: rtl/io_pkg.sv
// Shared constants for the bus I/O port FIFO: default width and the bit
// positions of the status and sticky error vectors.
package io_pkg;

    localparam int IO_WIDTH = 16;
    localparam int IO_DEPTH = 4;

    localparam int TX_FULL  = 3;
    localparam int TX_EMPTY = 2;
    localparam int RX_FULL  = 1;
    localparam int RX_EMPTY = 0;

    localparam int TX_OVF = 1;
    localparam int RX_UDF = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Push on full and pop on empty are ignored; the caller decides what that means.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1))
            return '0;
        return ptr + PW'(1);
    endfunction

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push_ok)
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (pop_ok)
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        if (push_ok && !pop_ok)
            count_next = count_reg + PW'(1);
        else if (pop_ok && !push_ok)
            count_next = count_reg - PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == PW'(DEPTH));
            empty_reg  <= (count_next == '0);
        end
    end

    // Storage carries no reset: stale words are never visible while empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/io_port_fifo.sv
// Buffered CPU-bus I/O port: TX FIFO to a valid/ready consumer, RX FIFO read
// back onto the tri-state bus, legacy exit register and sticky error flags.
module io_port_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             io_en,
    input  logic             io_out,
    input  logic             io_rd,
    output wire  [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] exit,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [3:0]       status,
    output logic [1:0]       err,
    input  logic             err_clr
);

    logic             tx_full, tx_empty;
    logic             rx_full, rx_empty;
    logic [WIDTH-1:0] tx_head, rx_head;
    logic [WIDTH-1:0] exit_reg;
    logic [1:0]       err_reg, err_next;
    logic [1:0]       err_event;
    logic [WIDTH-1:0] bus_val;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (io_en),
        .pop     (tx_ready),
        .wr_data (bus_in),
        .head    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rx_valid),
        .pop     (io_rd),
        .wr_data (rx_data),
        .head    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_comb begin
        err_event          = '0;
        err_event[TX_OVF]  = io_en && tx_full;
        err_event[RX_UDF]  = io_rd && rx_empty;
        // A clear loses to an error raised in the same cycle.
        err_next = err_clr ? err_event : (err_reg | err_event);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_reg <= '0;
            err_reg  <= '0;
        end else begin
            if (io_en && !tx_full)
                exit_reg <= bus_in;
            err_reg <= err_next;
        end
    end

    always_comb begin
        status           = '0;
        status[TX_FULL]  = tx_full;
        status[TX_EMPTY] = tx_empty;
        status[RX_FULL]  = rx_full;
        status[RX_EMPTY] = rx_empty;
    end

    assign bus_val  = rx_empty ? '0 : rx_head;
    assign bus_out  = io_out ? bus_val : {WIDTH{1'bz}};

    assign exit     = exit_reg;
    assign err      = err_reg;
    assign tx_data  = tx_head;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

endmodule
